// File: rtl/multi_unit_scheduler_if.sv
// Bus bundle between the requester fabric, the scheduler and the shared multi-cycle unit.
// slave = scheduler side, master = fabric/unit environment side.
interface multi_unit_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [ID_W-1:0]          resp_id;
   logic [WIDTH-1:0]         resp_data;
   logic                     resp_error;
   logic                     unit_reset;
   logic                     unit_start;
   logic [WIDTH-1:0]         unit_in;
   logic                     unit_done;
   logic [WIDTH-1:0]         unit_out;

   modport slave (
      input  req_valid, req_data, resp_ready, unit_done, unit_out,
      output req_ready, resp_valid, resp_id, resp_data, resp_error,
             unit_reset, unit_start, unit_in
   );

   modport master (
      output req_valid, req_data, resp_ready, unit_done, unit_out,
      input  req_ready, resp_valid, resp_id, resp_data, resp_error,
             unit_reset, unit_start, unit_in
   );
endinterface

// File: rtl/multi_unit_scheduler.sv
// Round-robin scheduler sharing one multi-cycle unit between NUM_REQ requesters,
// one job in flight, result held until taken, unit recovered on timeout.
//
// state  | meaning
// IDLE   | arbitrate requesters, accept one job
// ISSUE  | one-cycle unit_start with the latched job
// WAIT   | wait for unit_done or abort at TIMEOUT
// RESP   | present result until resp_ready
module multi_unit_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 64,
   parameter int ID_W    = 2
) (
   input  logic clock,
   input  logic reset_n,
   multi_unit_scheduler_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]      state;
   logic [ID_W-1:0] prio_ptr;
   logic [ID_W-1:0] id_q;
   logic [ID_W-1:0] grant;
   logic [WIDTH-1:0] job_q;
   logic [WIDTH-1:0] res_q;
   logic            err_q;
   logic            rst_hold;
   logic [TW-1:0]   timer;
   logic            any_req;
   logic            accept;
   logic            timeout_hit;

   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [ID_W-1:0]    ptr);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && v[idx[ID_W-1:0]]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
      return pick;
   endfunction

   assign grant   = rr_pick(bus.req_valid, prio_ptr);
   assign any_req = |bus.req_valid;
   // rst_hold keeps the fabric out while the unit is still being reset
   assign accept  = (state == S_IDLE) && any_req && !rst_hold;

   // Done in the final WAIT cycle beats the timeout
   assign timeout_hit = (state == S_WAIT) && !bus.unit_done &&
                        (timer == TW'(TIMEOUT - 1));

   assign bus.req_ready  = accept ? (NUM_REQ'(1) << grant) : '0;
   assign bus.unit_start = (state == S_ISSUE);
   assign bus.unit_in    = job_q;
   assign bus.unit_reset = rst_hold | timeout_hit;
   assign bus.resp_valid = (state == S_RESP);
   assign bus.resp_id    = (state == S_RESP) ? id_q  : '0;
   assign bus.resp_data  = (state == S_RESP) ? res_q : '0;
   assign bus.resp_error = (state == S_RESP) ? err_q : 1'b0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         prio_ptr <= '0;
         id_q     <= '0;
         job_q    <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         timer    <= '0;
         rst_hold <= 1'b1;
      end else begin
         rst_hold <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  job_q <= bus.req_data[grant*WIDTH +: WIDTH];
                  id_q  <= grant;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (bus.unit_done) begin
                  res_q <= bus.unit_out;
                  err_q <= 1'b0;
                  state <= S_RESP;
               end else if (timeout_hit) begin
                  res_q <= '0;
                  err_q <= 1'b1;
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.resp_ready) begin
                  prio_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_multi_unit_scheduler.sv
// Randomized bench for multi_unit_scheduler: the bench plays requesters, consumer and the
// shared unit, and predicts grants/results from a transaction-level round-robin model.
module tb_multi_unit_scheduler;
   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 64;
   localparam int ID_W    = 2;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   multi_unit_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

   multi_unit_scheduler #(
      .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int ptr_m    = 0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Round-robin reference: first valid requester at or after the pointer, wrapping
   function automatic int rr_ref(input logic [3:0] m, input int p);
      int idx;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (p + k) % NUM_REQ;
         if (m[idx[1:0]]) return idx;
      end
      return 0;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         bus.req_valid  = '0;
         bus.resp_ready = 1'b0;
         bus.unit_done  = 1'b0;
         #1;
         check_val("idle_req_ready", 32'(bus.req_ready), 32'd0);
         check_val("idle_unit_start", 32'(bus.unit_start), 32'd0);
         check_val("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
         check_val("idle_unit_reset", 32'(bus.unit_reset), 32'd0);
      end
   endtask

   // lat = 0 means the unit never answers; otherwise done arrives lat cycles after start
   task automatic do_job(input logic [3:0] mask, input int lat, input int hold,
                         input logic [31:0] xr);
      logic [31:0] d [NUM_REQ];
      logic [31:0] exp_res;
      logic [31:0] exp_err;
      logic        dn;
      int          g;
      tick();
      bus.resp_ready = 1'b0;
      bus.unit_done  = 1'b0;
      bus.req_valid  = mask;
      for (int i = 0; i < NUM_REQ; i++) begin
         d[i] = $urandom;
         bus.req_data[i*WIDTH +: WIDTH] = d[i];
      end
      #1;
      g = rr_ref(mask, ptr_m);
      check_val("grant", 32'(bus.req_ready), 32'd1 << g);
      check_val("accept_resp_valid", 32'(bus.resp_valid), 32'd0);

      tick();
      bus.req_valid = 4'($urandom);
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check_val("issue_start", 32'(bus.unit_start), 32'd1);
      check_val("issue_unit_in", bus.unit_in, d[g]);
      check_val("issue_req_ready", 32'(bus.req_ready), 32'd0);

      exp_res = 32'd0;
      exp_err = 32'd1;
      for (int c = 0; c < TIMEOUT; c++) begin
         tick();
         dn = (lat > 0) && (c == lat - 1);
         bus.unit_done = dn;
         bus.unit_out  = dn ? (d[g] ^ xr) : $urandom;
         #1;
         check_val("wait_start", 32'(bus.unit_start), 32'd0);
         check_val("wait_resp_valid", 32'(bus.resp_valid), 32'd0);
         check_val("wait_unit_in", bus.unit_in, d[g]);
         check_val("wait_unit_reset", 32'(bus.unit_reset), 32'(!dn && (c == TIMEOUT - 1)));
         if (dn) begin
            exp_res = d[g] ^ xr;
            exp_err = 32'd0;
            break;
         end
      end

      for (int h = 0; h <= hold; h++) begin
         tick();
         bus.unit_done  = 1'($urandom);
         bus.unit_out   = $urandom;
         bus.req_valid  = 4'hF;
         bus.resp_ready = (h == hold);
         #1;
         check_val("resp_valid", 32'(bus.resp_valid), 32'd1);
         check_val("resp_id", 32'(bus.resp_id), 32'(g));
         check_val("resp_data", bus.resp_data, exp_res);
         check_val("resp_error", 32'(bus.resp_error), exp_err);
         check_val("resp_req_ready", 32'(bus.req_ready), 32'd0);
         check_val("resp_start", 32'(bus.unit_start), 32'd0);
         check_val("resp_unit_reset", 32'(bus.unit_reset), 32'd0);
      end
      ptr_m = (g + 1) % NUM_REQ;
   endtask

   initial begin
      int g;
      bus.req_valid  = 4'hF;
      bus.req_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.resp_ready = 1'b0;
      bus.unit_done  = 1'b0;
      bus.unit_out   = '0;
      #12;
      check_val("rst_unit_reset", 32'(bus.unit_reset), 32'd1);
      check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_val("rst_unit_start", 32'(bus.unit_start), 32'd0);
      check_val("rst_unit_in", bus.unit_in, 32'd0);
      check_val("rst_resp_data", bus.resp_data, 32'd0);
      tick();
      reset_n       = 1'b1;
      bus.req_valid = '0;
      #1;
      check_val("release_unit_reset", 32'(bus.unit_reset), 32'd1);
      idle(2);

      // Round-robin wrap with everyone requesting
      for (int i = 0; i < 5; i++) do_job(4'hF, int'($urandom_range(1, 4)), 0, $urandom);
      do_job(4'b0010, 3, 0, 32'd0);
      do_job(4'hF, 2, 10, $urandom);
      // Timeout abort, then a normal job
      do_job(4'b0101, 0, 1, $urandom);
      do_job(4'b0101, 2, 0, $urandom);
      // Done on the last WAIT cycle
      do_job(4'hF, TIMEOUT, 0, $urandom);

      for (int i = 0; i < 40; i++) begin
         idle(int'($urandom_range(0, 2)));
         do_job(4'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
                int'($urandom_range(0, 3)), $urandom);
      end

      // Reset in WAIT: job dropped, pointer back to 0
      do_job(4'b0100, 2, 0, $urandom);
      tick();
      bus.req_valid = 4'hF;
      bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      g = rr_ref(4'hF, ptr_m);
      check_val("mid_grant", 32'(bus.req_ready), 32'd1 << g);
      tick();
      tick();
      tick();
      #1;
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_unit_reset", 32'(bus.unit_reset), 32'd1);
      check_val("mid_rst_unit_start", 32'(bus.unit_start), 32'd0);
      check_val("mid_rst_unit_in", bus.unit_in, 32'd0);
      check_val("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_val("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
      check_val("mid_rst_hold_reset", 32'(bus.unit_reset), 32'd1);
      reset_n       = 1'b1;
      bus.req_valid = '0;
      ptr_m         = 0;
      idle(2);
      do_job(4'b1010, 2, 0, $urandom);
      do_job(4'b1000, 3, 0, $urandom);
      for (int i = 0; i < 6; i++) do_job(4'hF, int'($urandom_range(1, 5)), 0, $urandom);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
